// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor with a carry chain split into STAGE_W-bit ripple
// segments, one segment resolved per pipeline register, valid/ready flow control.
//
// Ports:
//   clk, rst         single clock, asynchronous active-high reset
//   in_valid/ready   operand handshake (a, b, op, cin)
//   op               00 ADD, 01 SUB, 10 ADD+carry-in, 11 SUB+borrow-in
//   out_valid/ready  result handshake (result, cout, ovf, zero)
//   cout             carry out of the MSB; for SUB ops 1 means no borrow
//   ovf              two's-complement signed overflow
//   zero             result equals zero
module pipelined_add_sub #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned STAGE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = (STAGE_W == 0) ? 1 : WIDTH / STAGE_W;
  localparam int unsigned LAST   = STAGES - 1;
  localparam bit BAD_WIDTH = (STAGE_W == 0) ? 1'b1
                           : ((WIDTH == 0) || ((WIDTH % STAGE_W) != 0));

  // Refuse to elaborate a width that does not split into whole segments.
  generate
    if (BAD_WIDTH) begin : g_bad_width
      $error("pipelined_add_sub: WIDTH must be a nonzero multiple of STAGE_W");
    end
  endgenerate

  // Per-stage state. word_q holds resolved result bits below the stage
  // boundary and still-unresolved bits of a above it, so the word is the
  // final result once the last stage has written it.
  logic [WIDTH-1:0]  word_q  [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [1:0]        op_q    [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;
  logic              ovf_q;
  logic              zero_q;

  // Stage inputs (from ports for stage 0, from the previous register otherwise).
  logic [WIDTH-1:0]  src_word  [STAGES];
  logic [WIDTH-1:0]  src_b     [STAGES];
  logic [1:0]        src_op    [STAGES];
  logic [STAGES-1:0] src_carry;
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  nxt_word  [STAGES];
  logic [STAGES-1:0] nxt_carry;
  logic [STAGES:0]   ready_c;
  logic              ovf_c;
  logic              zero_c;

  // Stage input muxing, ready chain and per-segment ripple adders.
  always_comb begin
    logic [STAGE_W-1:0] seg_a;
    logic [STAGE_W-1:0] seg_b;
    logic [STAGE_W:0]   seg_sum;
    logic               msb_bp;

    seg_a   = '0;
    seg_b   = '0;
    seg_sum = '0;
    msb_bp  = 1'b0;

    src_word[0] = a;
    src_b[0]    = b;
    src_op[0]   = op;
    src_valid   = '0;
    src_carry   = '0;
    nxt_carry   = '0;
    src_valid[0] = in_valid;
    // Initial carry: SUB forms a + ~b + 1; borrow-in removes that +1.
    unique case (op)
      2'b00:   src_carry[0] = 1'b0;
      2'b01:   src_carry[0] = 1'b1;
      2'b10:   src_carry[0] = cin;
      default: src_carry[0] = ~cin;
    endcase
    for (int k = 1; k < int'(STAGES); k++) begin
      src_word[k]  = word_q[k-1];
      src_b[k]     = b_q[k-1];
      src_op[k]    = op_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_valid[k] = valid_q[k-1];
    end

    ready_c = '0;
    ready_c[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready_c[k] = !valid_q[k] || ready_c[k+1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      seg_a   = src_word[k][k*STAGE_W +: STAGE_W];
      seg_b   = src_op[k][0] ? ~src_b[k][k*STAGE_W +: STAGE_W]
                             :  src_b[k][k*STAGE_W +: STAGE_W];
      seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + (STAGE_W+1)'(src_carry[k]);
      nxt_word[k] = src_word[k];
      nxt_word[k][k*STAGE_W +: STAGE_W] = seg_sum[STAGE_W-1:0];
      nxt_carry[k] = seg_sum[STAGE_W];
    end

    // Flags from the final stage: the MSB of a is still unresolved there.
    msb_bp = src_op[LAST][0] ? ~src_b[LAST][WIDTH-1] : src_b[LAST][WIDTH-1];
    ovf_c  = (src_word[LAST][WIDTH-1] == msb_bp) &&
             (nxt_word[LAST][WIDTH-1] != src_word[LAST][WIDTH-1]);
    zero_c = (nxt_word[LAST] == '0);
  end

  // Pipeline registers: a stage advances whenever it is ready, and only
  // captures data when a valid entry is actually moving in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        word_q[k] <= '0;
        b_q[k]    <= '0;
        op_q[k]   <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ready_c[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            word_q[k]  <= nxt_word[k];
            b_q[k]     <= src_b[k];
            op_q[k]    <= src_op[k];
            carry_q[k] <= nxt_carry[k];
          end
        end
      end
      if (ready_c[LAST] && src_valid[LAST]) begin
        ovf_q  <= ovf_c;
        zero_q <= zero_c;
      end
    end
  end

  assign in_ready  = ready_c[0];
  assign out_valid = valid_q[LAST];
  assign result    = word_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (WIDTH=64, STAGE_W=16).
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_add_sub #(.WIDTH(64), .STAGE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic using a 65-bit integer sum/difference.
  function automatic logic [64:0] ref_calc(input logic [1:0] o, input logic [63:0] x,
                                           input logic [63:0] y, input logic ci);
    logic [64:0] r;
    case (o)
      2'b00:   r = {1'b0, x} + {1'b0, y};
      2'b10:   r = {1'b0, x} + {1'b0, y} + 65'(ci);
      2'b01: begin
        r = {1'b0, x} - {1'b0, y};
        r[64] = ~r[64];
      end
      default: begin
        r = {1'b0, x} - {1'b0, y} - 65'(ci);
        r[64] = ~r[64];
      end
    endcase
    return r;
  endfunction

  // One isolated operation: accept, confirm no early result, check at edge t+3.
  task automatic run_single(input string tag, input logic [1:0] o, input logic [63:0] x,
                            input logic [63:0] y, input logic ci, input logic [63:0] er,
                            input logic ec, input logic eo, input logic ez);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op = o; a = x; b = y; cin = ci;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 64'hDEAD_BEEF_DEAD_BEEF;
    b = 64'h1234_5678_9ABC_DEF0;
    op = 2'b11;
    for (int n = 1; n <= 3; n++) begin
      check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_valid"},  64'(out_valid), 64'd1);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"},   64'(cout), 64'(ec));
    check({tag, "_ovf"},    64'(ovf),  64'(eo));
    check({tag, "_zero"},   64'(zero), 64'(ez));
    @(posedge clk); #1;
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [63:0] sa   [8];
  logic [63:0] sb   [8];
  logic [1:0]  sop  [8];
  logic        scin [8];
  logic [63:0] sexp [8];

  initial begin
    int sent, recv, stall_sent, first_out, last_out;
    logic [64:0] r;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    @(posedge clk); #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_result",    result,         64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_zero",      64'(zero),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_single("add_ripple", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'd0, 1'b1, 1'b0, 1'b1);
    run_single("sub_ovf", 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_single("sub_borrow", 2'b01, 64'd3, 64'd5, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_single("sbb", 2'b11, 64'd10, 64'd3, 1'b1, 64'd6, 1'b1, 1'b0, 1'b0);
    run_single("adc", 2'b10, 64'd10, 64'd3, 1'b1, 64'd14, 1'b0, 1'b0, 1'b0);
    run_single("add_posovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_single("add_seg_carry", 2'b00, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000,
               1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    run_single("sub_zero_cin_ignored", 2'b01, 64'd5, 64'd5, 1'b1,
               64'd0, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream with a long output stall.
    for (int i = 0; i < 8; i++) begin
      sa[i]   = 64'h1111_1111_1111_1111 * 64'(i + 1);
      sb[i]   = 64'h0F0F_0000_FFFF_0001 + 64'(i);
      sop[i]  = 2'(i);
      scin[i] = (i >= 4);
      r = ref_calc(sop[i], sa[i], sb[i], scin[i]);
      sexp[i] = r[63:0];
    end
    sent = 0; recv = 0; stall_sent = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      out_ready = (c < 2) || (c >= 10);
      if (sent < 8) begin
        in_valid = 1'b1;
        a = sa[sent]; b = sb[sent]; op = sop[sent]; cin = scin[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready && stall_sent < 0) stall_sent = sent;
      if (c == 4 || c == 9) begin
        check("stall_valid",  64'(out_valid), 64'd1);
        check("stall_result", result, sexp[0]);
      end
      if (out_valid && out_ready) begin
        check("stream_result", result, sexp[recv]);
        if (first_out < 0) first_out = c;
        last_out = c;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count",      64'(recv),                 64'd8);
    check("stall_accepted",    64'(stall_sent),           64'd4);
    check("stream_first_out",  64'(first_out),            64'd10);
    check("stream_no_bubbles", 64'(last_out - first_out), 64'd7);
    @(posedge clk); #1;

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op = 2'b00; a = 64'(i + 100); b = 64'd1; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_result",    result,         64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_single("post_rst_add", 2'b00, 64'd2, 64'd2, 1'b0, 64'd4, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter STAGE_W, default 16: bits resolved per pipeline stage; STAGES = WIDTH/STAGE_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set a/b/op/cin is presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 op  input  2  00 ADD, 01 SUB, 10 ADD with carry-in, 11 SUB with borrow-in.
REQ-010 cin  input  1  carry-in (op 10) or active-high borrow-in (op 11); ignored for op 00/01.
REQ-011 out_valid  output  1  result and flags are valid.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1; for SUB ops 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  result equals 0.

Function
REQ-017 Elaboration SHALL fail if WIDTH is not a nonzero multiple of STAGE_W.
REQ-018 Operation SHALL be result = a + b' + c0; ADD: b'=b, c0=0; SUB: b'=~b, c0=1; op 10: b'=b, c0=cin; op 11: b'=~b, c0=~cin.
REQ-019 The carry chain SHALL be split into STAGES ripple segments of STAGE_W bits, one segment per pipeline register; stage k resolves bits [k*STAGE_W +: STAGE_W] using the carry registered by stage k-1.
REQ-020 Unresolved upper operand bits and op SHALL travel with each entry; result bits already resolved SHALL be carried forward unchanged.
REQ-021 Transfer into the block occurs on a rising edge where in_valid && in_ready; transfer out occurs where out_valid && out_ready.
REQ-022 Each stage k SHALL hold a valid bit; ready_k = !valid_k || ready_(k+1), with ready after the last stage = out_ready; in_ready = ready_0.
REQ-023 Latency: an entry accepted on edge t SHALL present out_valid=1 after edge t+STAGES-1 when no back-pressure occurs (STAGES=1: registered adder, result after the accepting edge).
REQ-024 Throughput SHALL be one operation per cycle while out_ready=1; no bubbles inserted.
REQ-025 When out_ready=0, output entry and all flags SHALL hold stable; upstream stages fill; in_ready=0 only when all STAGES registers are valid and out_ready=0.
REQ-026 Simultaneous accept and drain on a full pipeline SHALL both occur in the same edge with no loss or duplication.
REQ-027 Order SHALL be preserved: results emerge in acceptance order.
REQ-028 ovf = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]); zero and ovf SHALL be computed in the final stage and registered with result.
REQ-029 Data inputs SHALL be ignored when in_valid=0; outputs other than out_valid are don't-care while out_valid=0 but SHALL not be X after reset.

Reset
REQ-030 rst=1 SHALL immediately clear every stage valid bit: out_valid=0, in_ready=1, result=0, cout=0, ovf=0, zero=0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries; first accept after rst deasserts behaves as from empty.

Verification (WIDTH=64, STAGE_W=16, latency 4 edges)
REQ-032 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> after edge t+3: result=0, cout=1, zero=1, ovf=0 (carry ripples across all 4 segments).
REQ-033 SUB a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1; SUB a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0.
REQ-034 op 11 a=10, b=3, cin=1 -> result=6; op 10 a=10, b=3, cin=1 -> result=14.
REQ-035 Stream 8 back-to-back ops, hold out_ready=0 from cycle 2 -> in_ready drops after 4 held entries, outputs stable; release -> all 8 results in order, one per cycle.
REQ-036 Assert rst with 3 entries in flight -> out_valid=0 at once; after release, new ADD 2+2 -> result=4 exactly 4 edges after acceptance, no stale results.
